// File: rtl/ps2_rx.sv
// ps2_rx -- host-side PS/2 receive front end.
//
// Synchronizes the open-collector PS/2 pins, debounces the PS/2 clock,
// deserializes 11-bit device-to-host frames (start, 8 data LSB first, odd
// parity, stop) and reports each frame with a single one-cycle status pulse.
//
// Parameters:
//   FILTER_LEN  consecutive equal clock samples before the filtered clock moves (1..255)
//   TIMEOUT     sys clocks allowed between PS/2 falling edges inside a frame
// Optional feature:
//   PS2_RX_TIMEOUT_EN  when defined, an in-frame edge timeout aborts the frame
//                      to IDLE with an rx_frame_err pulse.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   ps2_clk, ps2_data PS/2 pins (asynchronous, idle high)
//   rx_en             accept new frames (sampled only in IDLE)
//   rx_data           last good byte, updated with rx_valid
//   rx_valid          frame ok pulse
//   rx_parity_err     parity error pulse
//   rx_frame_err      stop bit error / timeout pulse
//   rx_busy           frame in progress
module ps2_rx #(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       rx_en,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  if (FILTER_LEN < 1 || FILTER_LEN > 255 || TIMEOUT < 1) begin : g_param_check
    $error("ps2_rx: FILTER_LEN must be 1..255 and TIMEOUT at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic       clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic [7:0] flt_cnt_q, flt_cnt_d;
  logic       clk_filt_q, clk_filt_d, clk_filt_dly_q;
  logic       fall;
  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic       par_q, par_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  // Filter: the filtered clock follows the synchronized pin only after it
  // has differed for FILTER_LEN consecutive samples.
  always_comb begin
    flt_cnt_d  = flt_cnt_q;
    clk_filt_d = clk_filt_q;
    if (clk_s2_q == clk_filt_q) begin
      flt_cnt_d = '0;
    end else if (flt_cnt_q == 8'(FILTER_LEN - 1)) begin
      clk_filt_d = clk_s2_q;
      flt_cnt_d  = '0;
    end else begin
      flt_cnt_d = flt_cnt_q + 8'd1;
    end
  end

  // Edge taken from registered copies so the status pulse lands a fixed
  // 2 + FILTER_LEN + 1 clocks after the pin edge.
  assign fall = clk_filt_dly_q & ~clk_filt_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_d     = par_q;
    rx_data_d = rx_data_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (fall && rx_en && !dat_s2_q) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (fall) begin
          shreg_d   = {dat_s2_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (fall) begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          state_d = S_IDLE;
          if (!dat_s2_q) begin
            ferr_d = 1'b1;
          end else if (^{shreg_q, par_q}) begin
            valid_d   = 1'b1;
            rx_data_d = shreg_q;
          end else begin
            perr_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef PS2_RX_TIMEOUT_EN
    tmo_cnt_d = (state_q == S_IDLE || fall) ? '0 : tmo_cnt_q + 1'b1;
    if (state_q != S_IDLE && !fall && tmo_cnt_q == TMO_W'(TIMEOUT)) begin
      state_d = S_IDLE;
      ferr_d  = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1_q       <= 1'b1;
      clk_s2_q       <= 1'b1;
      dat_s1_q       <= 1'b1;
      dat_s2_q       <= 1'b1;
      flt_cnt_q      <= '0;
      clk_filt_q     <= 1'b1;
      clk_filt_dly_q <= 1'b1;
      state_q        <= S_IDLE;
      bit_cnt_q      <= '0;
      shreg_q        <= '0;
      par_q          <= 1'b0;
      rx_data_q      <= '0;
      valid_q        <= 1'b0;
      perr_q         <= 1'b0;
      ferr_q         <= 1'b0;
`ifdef PS2_RX_TIMEOUT_EN
      tmo_cnt_q      <= '0;
`endif
    end else begin
      clk_s1_q       <= ps2_clk;
      clk_s2_q       <= clk_s1_q;
      dat_s1_q       <= ps2_data;
      dat_s2_q       <= dat_s1_q;
      flt_cnt_q      <= flt_cnt_d;
      clk_filt_q     <= clk_filt_d;
      clk_filt_dly_q <= clk_filt_q;
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shreg_q        <= shreg_d;
      par_q          <= par_d;
      rx_data_q      <= rx_data_d;
      valid_q        <= valid_d;
      perr_q         <= perr_d;
      ferr_q         <= ferr_d;
`ifdef PS2_RX_TIMEOUT_EN
      tmo_cnt_q      <= tmo_cnt_d;
`endif
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_valid      = valid_q;
  assign rx_parity_err = perr_q;
  assign rx_frame_err  = ferr_q;
  assign rx_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_ps2_rx.sv
// Directed testbench for ps2_rx: device-model frames with hand-computed
// expected bytes, status pulses, latency and busy behaviour.
module tb_ps2_rx;

  localparam int unsigned TMO = 5000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rx_en = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_parity_err, rx_frame_err, rx_busy;

  int n_checks = 0;
  int n_fail = 0;
  int unsigned cyc = 0;
  int n_valid = 0, n_perr = 0, n_ferr = 0;
  int unsigned t_valid = 0, t_perr = 0, t_ferr = 0;
  int unsigned last_fall = 0;
  int half = 500;

  ps2_rx #(.FILTER_LEN(8), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rx_en(rx_en), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid)      begin n_valid++; t_valid = cyc; end
    if (rx_parity_err) begin n_perr++;  t_perr  = cyc; end
    if (rx_frame_err)  begin n_ferr++;  t_ferr  = cyc; end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Device model: data changes while the clock is high, host samples on fall.
  task automatic send_frame(input logic [7:0] b, input bit perr, input logic stopv,
                            input int nbits, input bit glitch);
    logic [10:0] fr;
    logic        p;
    p  = (~^b) ^ perr;
    fr = {stopv, p, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      wait_clks(half / 4);
      if (glitch) begin
        ps2_clk = 1'b0; wait_clks(5); ps2_clk = 1'b1;
      end
      wait_clks(half / 4);
      ps2_clk   = 1'b0;
      last_fall = cyc;
      wait_clks(half);
      ps2_clk = 1'b1;
      wait_clks(half / 2);
    end
    ps2_data = 1'b1;
  endtask

  task automatic test_reset;
    wait_clks(3);
    n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", rx_data); end
    n_checks++; if ({rx_valid, rx_parity_err, rx_frame_err, rx_busy} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {rx_valid, rx_parity_err, rx_frame_err, rx_busy});
    end
    reset = 1'b0;
    wait_clks(20);
    n_checks++; if (rx_busy !== 1'b0 || n_ferr != 0 || n_valid != 0) begin
      n_fail++; $display("FAIL reset_release: busy %b valid %0d ferr %0d expected 0 0 0", rx_busy, n_valid, n_ferr);
    end
  endtask

  task automatic test_valid;
    int v0, p0, f0;
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    half = 500;
    send_frame(8'hA5, 1'b0, 1'b1, 11, 1'b0);
    n_checks++; if (n_valid - v0 != 1) begin n_fail++; $display("FAIL a5_valid_count: got %0d expected 1", n_valid - v0); end
    n_checks++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL a5_data: got %h expected a5", rx_data); end
    n_checks++; if (t_valid - last_fall != 11) begin n_fail++; $display("FAIL a5_latency: got %0d expected 11", t_valid - last_fall); end
    n_checks++; if (n_perr != p0 || n_ferr != f0 || rx_busy !== 1'b0) begin
      n_fail++; $display("FAIL a5_no_err: perr %0d ferr %0d busy %b expected 0 0 0", n_perr - p0, n_ferr - f0, rx_busy);
    end
    half = 150;
  endtask

  task automatic test_parity_err;
    int v0, p0, f0;
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    send_frame(8'h3C, 1'b1, 1'b1, 11, 1'b0);
    n_checks++; if (n_perr - p0 != 1) begin n_fail++; $display("FAIL par_count: got %0d expected 1", n_perr - p0); end
    n_checks++; if (n_valid != v0 || n_ferr != f0) begin n_fail++; $display("FAIL par_other: valid %0d ferr %0d expected 0 0", n_valid - v0, n_ferr - f0); end
    n_checks++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL par_data_kept: got %h expected a5", rx_data); end
    n_checks++; if (t_perr - last_fall != 11) begin n_fail++; $display("FAIL par_latency: got %0d expected 11", t_perr - last_fall); end
  endtask

  task automatic test_frame_err;
    int v0, p0, f0;
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    send_frame(8'h00, 1'b0, 1'b0, 11, 1'b0);
    n_checks++; if (n_ferr - f0 != 1) begin n_fail++; $display("FAIL stop_count: got %0d expected 1", n_ferr - f0); end
    n_checks++; if (n_valid != v0 || n_perr != p0) begin n_fail++; $display("FAIL stop_other: valid %0d perr %0d expected 0 0", n_valid - v0, n_perr - p0); end
    n_checks++; if (rx_busy !== 1'b0 || rx_data !== 8'hA5) begin
      n_fail++; $display("FAIL stop_idle: busy %b data %h expected 0 a5", rx_busy, rx_data);
    end
    v0 = n_valid;
    send_frame(8'hFF, 1'b0, 1'b1, 11, 1'b0);
    n_checks++; if (n_valid - v0 != 1 || rx_data !== 8'hFF) begin
      n_fail++; $display("FAIL ff_after_err: valid %0d data %h expected 1 ff", n_valid - v0, rx_data);
    end
  endtask

  task automatic test_glitch;
    int v0, p0, f0;
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    ps2_data = 1'b0;  // a leaked edge here would start a frame
    for (int i = 0; i < 3; i++) begin
      ps2_clk = 1'b0; wait_clks(5); ps2_clk = 1'b1; wait_clks(30);
    end
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle_busy: got %b expected 0", rx_busy); end
    ps2_data = 1'b1;
    wait_clks(30);
    send_frame(8'h12, 1'b0, 1'b1, 11, 1'b1);
    n_checks++; if (n_valid - v0 != 1 || rx_data !== 8'h12) begin
      n_fail++; $display("FAIL glitch_data: valid %0d data %h expected 1 12", n_valid - v0, rx_data);
    end
    n_checks++; if (n_perr != p0 || n_ferr != f0) begin n_fail++; $display("FAIL glitch_err: perr %0d ferr %0d expected 0 0", n_perr - p0, n_ferr - f0); end
  endtask

  task automatic test_rx_en;
    int v0, p0, f0;
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    rx_en = 1'b0;
    send_frame(8'h55, 1'b0, 1'b1, 11, 1'b0);
    n_checks++; if (n_valid != v0 || n_perr != p0 || n_ferr != f0 || rx_busy !== 1'b0) begin
      n_fail++; $display("FAIL rx_en_off: valid %0d perr %0d ferr %0d busy %b expected 0 0 0 0",
                         n_valid - v0, n_perr - p0, n_ferr - f0, rx_busy);
    end
    rx_en = 1'b1;
  endtask

  task automatic test_reset_mid;
    int v0, p0, f0;
    v0 = n_valid; p0 = n_perr; f0 = n_ferr;
    send_frame(8'h81, 1'b0, 1'b1, 5, 1'b0);
    n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b expected 1", rx_busy); end
    reset = 1'b1;
    #1;
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b expected 0", rx_busy); end
    wait_clks(10);
    reset = 1'b0;
    wait_clks(50);
    n_checks++; if (n_valid != v0 || n_perr != p0 || n_ferr != f0 || rx_data !== 8'h00) begin
      n_fail++; $display("FAIL mid_no_pulse: valid %0d perr %0d ferr %0d data %h expected 0 0 0 00",
                         n_valid - v0, n_perr - p0, n_ferr - f0, rx_data);
    end
    send_frame(8'h81, 1'b0, 1'b1, 11, 1'b0);
    n_checks++; if (n_valid - v0 != 1 || rx_data !== 8'h81) begin
      n_fail++; $display("FAIL mid_second: valid %0d data %h expected 1 81", n_valid - v0, rx_data);
    end
  endtask

  task automatic test_timeout;
    int f0;
    f0 = n_ferr;
    send_frame(8'h5A, 1'b0, 1'b1, 4, 1'b0);
    n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL tmo_busy_start: got %b expected 1", rx_busy); end
    for (int i = 0; i < TMO + 1000 && n_ferr == f0; i++) @(negedge clk);
`ifdef PS2_RX_TIMEOUT_EN
    n_checks++; if (n_ferr - f0 != 1) begin n_fail++; $display("FAIL tmo_pulse: got %0d expected 1", n_ferr - f0); end
    n_checks++; if (t_ferr - last_fall < TMO || t_ferr - last_fall > TMO + 20) begin
      n_fail++; $display("FAIL tmo_latency: got %0d expected %0d..%0d", t_ferr - last_fall, TMO, TMO + 20);
    end
    wait_clks(2);
    n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy_end: got %b expected 0", rx_busy); end
`else
    n_checks++; if (n_ferr != f0 || rx_busy !== 1'b1) begin
      n_fail++; $display("FAIL no_tmo_wait: ferr %0d busy %b expected 0 1", n_ferr - f0, rx_busy);
    end
    reset = 1'b1; wait_clks(2); reset = 1'b0; wait_clks(5);
`endif
  endtask

  initial begin
    test_reset();
    test_valid();
    test_parity_err();
    test_frame_err();
    test_glitch();
    test_rx_en();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
